// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder controller.
// Define SERIAL_ADDER_OVF_EN at build time to add the signed overflow flag.
package serial_adder_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/fa_bit.sv
// One-bit full adder: the only arithmetic cell in the serial datapath.
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder, LSB first, one bit per clock through a single fa_bit.
// Optional signed overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);

    state_t           state;
    state_t           nstate;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             fa_s;
    logic             fa_co;
    logic             last;

    fa_bit u_fa (
        .a  (op_a[0]),
        .b  (op_b[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    assign last = (cnt == CW'(WIDTH - 1));
    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nstate;
        end
    end

    always_comb begin
        nstate = state;
        unique case (state)
            IDLE:    if (start) nstate = RUN;
            RUN:     if (last) nstate = DONE;
            DONE:    nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            carry <= 1'b0;
            op_a  <= '0;
            op_b  <= '0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
        end else if (state == IDLE && start) begin
            op_a  <= in_a;
            op_b  <= in_b;
            carry <= cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            // Result enters at the MSB so bit 0 lands in place after WIDTH shifts.
            sum   <= {fa_s, sum[WIDTH-1:1]};
            op_a  <= op_a >> 1;
            op_b  <= op_b >> 1;
            carry <= fa_co;
            cnt   <= cnt + 1'b1;
            if (last) begin
                cout <= fa_co;
`ifdef SERIAL_ADDER_OVF_EN
                ovf  <= carry ^ fa_co;
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl at WIDTH=8.
// Checks ovf only when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf;
`endif

    int total = 0;
    int bad   = 0;

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .in_a  (in_a),
        .in_b  (in_b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // Drives at the current negedge; returns at the negedge after done.
    task automatic run_op(input string tag, input logic [7:0] a,
                          input logic [7:0] b, input logic c,
                          input logic [7:0] es, input logic ec,
                          input logic eo);
        int lat;
        int busy_bad;
        logic [7:0] s_at;
        logic c_at;
        logic o_at;
        lat = 0;
        busy_bad = 0;
        s_at = 'x;
        c_at = 1'bx;
        o_at = 1'bx;
        start = 1'b1;
        in_a = a;
        in_b = b;
        cin = c;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            start = 1'b0;
            in_a = ~a;
            in_b = ~b;
            cin = ~c;
            if (!busy) busy_bad++;
            if (done) begin
                lat = i;
                s_at = sum;
                c_at = cout;
`ifdef SERIAL_ADDER_OVF_EN
                o_at = ovf;
`else
                o_at = eo;
`endif
                break;
            end
        end
        chk({tag, "_lat"}, lat, 9);
        chk({tag, "_busy"}, busy_bad, 0);
        chk({tag, "_sum"}, {24'd0, s_at}, {24'd0, es});
        chk({tag, "_cout"}, {31'd0, c_at}, {31'd0, ec});
`ifdef SERIAL_ADDER_OVF_EN
        chk({tag, "_ovf"}, {31'd0, o_at}, {31'd0, eo});
`endif
        @(negedge clk);
        chk({tag, "_done_end"}, {31'd0, done}, 0);
        chk({tag, "_idle"}, {31'd0, busy}, 0);
    endtask

    initial begin
        int nd;
        int first;
        int busy_bad;
        int idle_bad;
        int d0;
        int d1;
        int d2;
        logic [7:0] s_at;

        rst = 1'b1;
        start = 1'b0;
        in_a = 8'h00;
        in_b = 8'h00;
        cin = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_sum", {24'd0, sum}, 0);
        chk("rst_cout", {31'd0, cout}, 0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("rst_ovf", {31'd0, ovf}, 0);
`endif
        rst = 1'b0;
        @(negedge clk);

        run_op("t0f01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);

        // IDLE holds the result while inputs wiggle without start.
        in_a = 8'hAA;
        in_b = 8'h55;
        cin = 1'b1;
        repeat (3) @(negedge clk);
        chk("hold_sum", {24'd0, sum}, 32'h10);
        chk("hold_busy", {31'd0, busy}, 0);

        run_op("tff00c", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
        run_op("t7f01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        run_op("t8080", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);

        // Restart attempt and operand change mid-run must be ignored.
        start = 1'b1;
        in_a = 8'h12;
        in_b = 8'h34;
        cin = 1'b0;
        nd = 0;
        first = 0;
        busy_bad = 0;
        idle_bad = 0;
        s_at = 'x;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            start = (i == 3);
            if (i == 3) begin
                in_a = 8'hFF;
                in_b = 8'hFF;
                cin = 1'b1;
            end
            if (i <= 9 && !busy) busy_bad++;
            if (i > 9 && busy) idle_bad++;
            if (done) begin
                nd++;
                if (first == 0) begin
                    first = i;
                    s_at = sum;
                end
            end
        end
        chk("rep_lat", first, 9);
        chk("rep_ndone", nd, 1);
        chk("rep_sum", {24'd0, s_at}, 32'h46);
        chk("rep_busy", busy_bad, 0);
        chk("rep_noqueue", idle_bad, 0);

        // Reset in the 4th RUN cycle aborts without a done pulse.
        start = 1'b1;
        in_a = 8'h55;
        in_b = 8'h0A;
        nd = 0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) nd++;
            if (i == 4) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        if (done) nd++;
        chk("abort_ndone", nd, 0);
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_sum", {24'd0, sum}, 0);
        chk("abort_cout", {31'd0, cout}, 0);
        run_op("post_rst", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

        // Start held high: one accept per IDLE cycle following each DONE.
        start = 1'b1;
        in_a = 8'h03;
        in_b = 8'h04;
        cin = 1'b0;
        nd = 0;
        d0 = 0;
        d1 = 0;
        d2 = 0;
        idle_bad = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if ((i == 10 || i == 20) && busy) idle_bad++;
            if (done) begin
                nd++;
                if (nd == 1) d0 = i;
                if (nd == 2) d1 = i;
                if (nd == 3) d2 = i;
                chk("b2b_sum", {24'd0, sum}, 32'h07);
            end
        end
        start = 1'b0;
        chk("b2b_ndone", nd, 3);
        chk("b2b_d0", d0, 9);
        chk("b2b_d1", d1, 19);
        chk("b2b_d2", d2, 29);
        chk("b2b_idle", idle_bad, 0);
        @(negedge clk);
        chk("b2b_end", {31'd0, busy}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  reset, synchronous and active-high, single clock domain.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 in_a  input  WIDTH  operand A, captured on an accepted start.
REQ-006 in_b  input  WIDTH  operand B, captured on an accepted start.
REQ-007 cin  input  1  carry-in, captured on an accepted start.
REQ-008 busy  output  1  high while an operation is accepted and not complete.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 sum  output  WIDTH  result, held stable from done until the next accepted start.
REQ-011 cout  output  1  final carry-out, held like sum.
REQ-012 ovf  output  1  signed overflow flag; present only when SERIAL_ADDER_OVF_EN is defined.

Function
REQ-013 The block SHALL compute {cout,sum} = in_a + in_b + cin bit-serially through a single one-bit full-adder cell, LSB first, one bit per clock.
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 IDLE with start=1 SHALL, at that edge t, latch in_a, in_b and cin into internal registers, clear the bit counter and go to RUN.
REQ-016 IDLE with start=0 SHALL hold the state and all outputs.
REQ-017 RUN SHALL, on each edge, add the current operand LSBs plus the carry register, shift the sum bit in at the result MSB, shift the operands right, update the carry register and increment the counter.
REQ-018 RUN SHALL go to DONE on the edge that processes bit WIDTH-1 (edge t+WIDTH).
REQ-019 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-020 Latency: an accepted start at edge t SHALL give done=1 in the cycle after edge t+WIDTH, with sum and cout valid in that cycle.
REQ-021 busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-022 start in RUN or DONE SHALL be ignored without being queued; operands and outputs SHALL be unaffected.
REQ-023 Changes on in_a, in_b or cin after acceptance SHALL NOT affect the result in progress.
REQ-024 The result SHALL wrap modulo 2^WIDTH, with the carry-out reported on cout (for example, all-ones + 1 gives sum=0, cout=1).
REQ-025 During RUN, sum SHALL show the partially shifted value; consumers SHALL sample sum only when done=1 or in a later IDLE cycle.

Reset
REQ-026 rst=1 at an edge SHALL force IDLE and clear counter, carry, operand registers, sum, cout, done, busy and ovf, taking priority over start.
REQ-027 rst during RUN or DONE SHALL abort the operation with no done pulse; a start in the first cycle after reset release SHALL be accepted normally.

Configuration
REQ-028 With SERIAL_ADDER_OVF_EN defined, ovf SHALL equal (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1), be updated in step with cout, and be held like cout.
REQ-029 Without SERIAL_ADDER_OVF_EN, the ovf port and its carry-into-MSB register SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-030 Package serial_adder_pkg SHALL hold the FSM state typedef (IDLE/RUN/DONE) and the default width constant.
REQ-031 The one-bit adder SHALL be a separate combinational sub-module, fa_bit (ports a, b, ci, s, co), instantiated exactly once.
REQ-032 The counter width SHALL be clog2(WIDTH), and no WIDTH-bit adder SHALL be inferred.

Verification (WIDTH=8)
REQ-033 The bench SHALL cover: start, in_a=0x0F, in_b=0x01, cin=0 -> done exactly 9 cycles after the start edge; sum=0x10, cout=0, ovf=0.
REQ-034 The bench SHALL cover: in_a=0xFF, in_b=0x00, cin=1 -> sum=0x00, cout=1, ovf=0.
REQ-035 The bench SHALL cover: in_a=0x7F, in_b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1 (OVF_EN build); no ovf port in the other build.
REQ-036 The bench SHALL cover: in_a=0x12, in_b=0x34; start re-pulsed and operands changed in the 3rd RUN cycle -> sum=0x46, a single done pulse, busy high throughout.
REQ-037 The bench SHALL cover: rst pulsed in the 4th RUN cycle -> no done; busy=0, sum=0, cout=0 next cycle; a following start with 0x01+0x01 gives sum=0x02.
REQ-038 The bench SHALL cover: back-to-back starts held high -> a new operation is accepted in the IDLE cycle after each DONE, one done per operation, 10-cycle spacing.
